// File: rtl/hsi_mse_multi_if.sv
// Sample and reference word streams feeding the HSI best-match engine.
// The master drives valid/data, the slave (the engine) drives ready.
interface hsi_mse_multi_if #(
  parameter int unsigned WORD_WIDTH = 32
) ();
  logic                  sample_in_valid;
  logic                  sample_in_ready;
  logic [WORD_WIDTH-1:0] sample_in;
  logic                  ref_in_valid;
  logic                  ref_in_ready;
  logic [WORD_WIDTH-1:0] ref_in;

  modport master (
    output sample_in_valid, sample_in, ref_in_valid, ref_in,
    input  sample_in_ready, ref_in_ready
  );

  modport slave (
    input  sample_in_valid, sample_in, ref_in_valid, ref_in,
    output sample_in_ready, ref_in_ready
  );
endinterface

// File: rtl/hsi_mse_multi.sv
// Multi-lane HSI best-match engine: buffers one sample vector, then streams a
// reference library against it and reports the lowest squared/absolute distance.
module hsi_mse_multi #(
  parameter int unsigned WORD_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned LANES            = WORD_WIDTH / DATA_WIDTH,
  parameter int unsigned HSI_BANDS        = 128,
  parameter int unsigned MAX_WORDS        = HSI_BANDS / LANES,
  parameter int unsigned HSI_LIBRARY_SIZE = 256,
  parameter int unsigned LIB_ADDR         = $clog2(HSI_LIBRARY_SIZE),
  parameter int unsigned ACC_WIDTH        = 2 * DATA_WIDTH + $clog2(HSI_BANDS)
) (
  input  logic                       clk,
  input  logic                       rst,
  hsi_mse_multi_if.slave             bus,
  input  logic [$clog2(MAX_WORDS):0] band_words_in,
  input  logic [LIB_ADDR:0]          library_length_in,
  input  logic                       mode_in,
  input  logic                       start,
  output logic [LIB_ADDR-1:0]        ref_id_out,
  output logic [ACC_WIDTH-1:0]       dist_out,
  output logic                       done,
  output logic                       idle,
  output logic                       ready
);

  localparam int unsigned WC_W   = $clog2(MAX_WORDS) + 1;
  localparam int unsigned IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned LEN_W  = LIB_ADDR + 1;
  localparam int unsigned DIFF_W = DATA_WIDTH + 1;
  localparam int unsigned TERM_W = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                state;
  logic [WC_W-1:0]       bw_q;
  logic [LEN_W-1:0]      len_q;
  logic                  mode_q;
  logic [WC_W-1:0]       word_cnt;
  logic [LEN_W-1:0]      ref_cnt;
  logic [1:0]            flush_cnt;
  logic [WORD_WIDTH-1:0] buffer [MAX_WORDS];

  logic                  s1_valid;
  logic                  s1_first;
  logic                  s1_last;
  logic [LIB_ADDR-1:0]   s1_id;
  logic [TERM_W-1:0]     s1_term [LANES];
  logic                  s2_valid;
  logic                  s2_last;
  logic [LIB_ADDR-1:0]   s2_id;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  best_dist;
  logic [LIB_ADDR-1:0]   best_id;

  logic                  start_c;
  logic                  sample_acc_c;
  logic                  ref_acc_c;
  logic                  word_last_c;
  logic                  ref_last_c;
  logic [WORD_WIDTH-1:0] buf_word_c;
  logic [DIFF_W-1:0]     diff_c [LANES];
  logic [DATA_WIDTH-1:0] mag_c  [LANES];
  logic [TERM_W-1:0]     term_c [LANES];
  logic [ACC_WIDTH-1:0]  sum_c;

  assign start_c      = (state == S_IDLE) && start;
  assign sample_acc_c = bus.sample_in_valid && bus.sample_in_ready;
  assign ref_acc_c    = bus.ref_in_valid && bus.ref_in_ready;
  assign word_last_c  = (word_cnt == bw_q - WC_W'(1));
  assign ref_last_c   = (ref_cnt == len_q - LEN_W'(1));
  assign buf_word_c   = buffer[IDX_W'(word_cnt)];

  // Per-lane |ref - sample| then squared or passed through depending on mode.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      diff_c[i] = {1'b0, bus.ref_in[i*DATA_WIDTH +: DATA_WIDTH]}
                - {1'b0, buf_word_c[i*DATA_WIDTH +: DATA_WIDTH]};
      mag_c[i]  = diff_c[i][DATA_WIDTH] ? DATA_WIDTH'(-diff_c[i])
                                        : diff_c[i][DATA_WIDTH-1:0];
      term_c[i] = mode_q ? TERM_W'(mag_c[i])
                         : TERM_W'(mag_c[i]) * TERM_W'(mag_c[i]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + ACC_WIDTH'(s1_term[i]);
    end
  end

  // Sample buffer; contents are don't-care across reset.
  always_ff @(posedge clk) begin
    if (sample_acc_c) begin
      buffer[IDX_W'(word_cnt)] <= bus.sample_in;
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      bw_q                <= '0;
      len_q               <= '0;
      mode_q              <= 1'b0;
      word_cnt            <= '0;
      ref_cnt             <= '0;
      flush_cnt           <= '0;
      bus.sample_in_ready <= 1'b0;
      bus.ref_in_ready    <= 1'b0;
      done                <= 1'b0;
      idle                <= 1'b1;
      ready               <= 1'b1;
      ref_id_out          <= '0;
      dist_out            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bw_q     <= band_words_in;
            len_q    <= library_length_in;
            mode_q   <= mode_in;
            word_cnt <= '0;
            ref_cnt  <= '0;
            idle     <= 1'b0;
            ready    <= 1'b0;
            if (library_length_in == '0) begin
              state      <= S_DONE;
              done       <= 1'b1;
              ref_id_out <= '0;
              dist_out   <= '1;
            end else begin
              state               <= S_LOAD;
              bus.sample_in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (sample_acc_c) begin
            if (word_last_c) begin
              word_cnt            <= '0;
              bus.sample_in_ready <= 1'b0;
              bus.ref_in_ready    <= 1'b1;
              state               <= S_COMPUTE;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (ref_acc_c) begin
            if (word_last_c) begin
              word_cnt <= '0;
              ref_cnt  <= ref_cnt + LEN_W'(1);
              if (ref_last_c) begin
                bus.ref_in_ready <= 1'b0;
                flush_cnt        <= '0;
                state            <= S_FLUSH;
              end
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
        // Three cycles let the last vector clear lane, accumulate and compare stages.
        S_FLUSH: begin
          if (flush_cnt == 2'd2) begin
            state      <= S_DONE;
            done       <= 1'b1;
            ref_id_out <= best_id;
            dist_out   <= best_dist;
          end else begin
            flush_cnt <= flush_cnt + 2'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          idle  <= 1'b1;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 lane terms, stage 2 per-vector accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_id    <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_term[i] <= '0;
      end
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_id    <= '0;
      acc      <= '0;
    end else begin
      s1_valid <= ref_acc_c;
      if (ref_acc_c) begin
        s1_first <= (word_cnt == '0);
        s1_last  <= word_last_c;
        s1_id    <= LIB_ADDR'(ref_cnt);
        s1_term  <= term_c;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        acc     <= (s1_first ? '0 : acc) + sum_c;
        s2_last <= s1_last;
        s2_id   <= s1_id;
      end
    end
  end

  // Stage 3 compare; strict less-than keeps the lower ID on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_dist <= '1;
      best_id   <= '0;
    end else if (start_c) begin
      best_dist <= '1;
      best_id   <= '0;
    end else if (s2_valid && s2_last && (acc < best_dist)) begin
      best_dist <= acc;
      best_id   <= s2_id;
    end
  end

endmodule

// File: tb/tb_hsi_mse_multi.sv
// Directed self-checking bench for hsi_mse_multi at default parameters.
module tb_hsi_mse_multi;

  localparam int unsigned WW    = 32;
  localparam int unsigned LIBA  = 8;
  localparam int unsigned ACC_W = 39;
  localparam int unsigned BW_W  = 7;
  localparam int unsigned LEN_W = 9;

  logic              clk;
  logic              rst;
  logic [BW_W-1:0]   band_words_in;
  logic [LEN_W-1:0]  library_length_in;
  logic              mode_in;
  logic              start;
  logic [LIBA-1:0]   ref_id_out;
  logic [ACC_W-1:0]  dist_out;
  logic              done;
  logic              idle;
  logic              ready;

  logic [WW-1:0]     smp  [4];
  logic [WW-1:0]     refw [16];
  logic [ACC_W-1:0]  all_ones;

  int checks;
  int errors;

  hsi_mse_multi_if #(.WORD_WIDTH(WW)) bus ();

  hsi_mse_multi dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.slave),
    .band_words_in     (band_words_in),
    .library_length_in (library_length_in),
    .mode_in           (mode_in),
    .start             (start),
    .ref_id_out        (ref_id_out),
    .dist_out          (dist_out),
    .done              (done),
    .idle              (idle),
    .ready             (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic start_run(input int nw, input int nlib, input bit md);
    @(negedge clk);
    band_words_in     = BW_W'(nw);
    library_length_in = LEN_W'(nlib);
    mode_in           = md;
    start             = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_samples(input int nw, output bit to);
    int idx = 0;
    int g   = 0;
    while (idx < nw && g < 200) begin
      bus.sample_in_valid = 1'b1;
      bus.sample_in       = smp[idx];
      if (bus.sample_in_ready) idx++;
      @(negedge clk);
      g++;
    end
    bus.sample_in_valid = 1'b0;
    to = (idx < nw);
  endtask

  task automatic feed_refs(input int nwords, input int stall_pct, input bit poke, output bit to);
    int idx   = 0;
    int g     = 0;
    bit poked = 1'b0;
    while (idx < nwords && g < 500) begin
      start = 1'b0;
      if (poke && !poked && idx == nwords / 2) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
        bus.ref_in_valid = 1'b0;
      end else begin
        bus.ref_in_valid = 1'b1;
        bus.ref_in       = refw[idx];
      end
      if (bus.ref_in_valid && bus.ref_in_ready) idx++;
      @(negedge clk);
      g++;
    end
    start            = 1'b0;
    bus.ref_in_valid = 1'b0;
    to = (idx < nwords);
  endtask

  // Offsets are cycles after the cycle in which the last reference was accepted.
  task automatic wait_done(output int done_off, output int done_cnt, output logic idle5);
    done_off = -1;
    done_cnt = 0;
    idle5    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (done === 1'b1) begin
        if (done_off < 0) done_off = k;
        done_cnt++;
      end
      if (k == 5) idle5 = idle;
      @(negedge clk);
    end
  endtask

  task automatic load_test1;
    smp[0]  = 32'h0002_0001; smp[1]  = 32'h0004_0003;
    refw[0] = 32'h0002_0002; refw[1] = 32'h0004_0003;
    refw[2] = 32'h0002_0001; refw[3] = 32'h0004_0003;
    refw[4] = 32'h0009_0009; refw[5] = 32'h0009_0009;
  endtask

  task automatic run_and_check(input string tag, input int nlib, input bit md, input int stall,
                               input bit poke, input logic [LIBA-1:0] exp_id,
                               input logic [ACC_W-1:0] exp_dist);
    bit to_s, to_r;
    int off, cnt;
    logic idle5;
    start_run(2, nlib, md);
    feed_samples(2, to_s);
    feed_refs(2 * nlib, stall, poke, to_r);
    wait_done(off, cnt, idle5);
    checks++;
    if (to_s || to_r) begin
      errors++;
      $display("FAIL %s_stream: handshake timeout sample=%0b ref=%0b", tag, to_s, to_r);
    end
    checks++;
    if (off != 4) begin errors++; $display("FAIL %s_done_latency: got %0d exp 4", tag, off); end
    checks++;
    if (cnt != 1) begin errors++; $display("FAIL %s_done_pulses: got %0d exp 1", tag, cnt); end
    checks++;
    if (idle5 !== 1'b1) begin errors++; $display("FAIL %s_idle_after: got %0b exp 1", tag, idle5); end
    checks++;
    if (ref_id_out !== exp_id) begin
      errors++; $display("FAIL %s_id: got %0d exp %0d", tag, ref_id_out, exp_id);
    end
    checks++;
    if (dist_out !== exp_dist) begin
      errors++; $display("FAIL %s_dist: got 0x%0h exp 0x%0h", tag, dist_out, exp_dist);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (idle !== 1'b1 || ready !== 1'b1) begin
      errors++; $display("FAIL reset_idle_ready: got %0b/%0b exp 1/1", idle, ready);
    end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b exp 0", done); end
    checks++;
    if (bus.sample_in_ready !== 1'b0 || bus.ref_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_readies: got %0b/%0b exp 0/0", bus.sample_in_ready, bus.ref_in_ready);
    end
    checks++;
    if (ref_id_out !== '0 || dist_out !== '0) begin
      errors++; $display("FAIL reset_results: got %0d/0x%0h exp 0/0", ref_id_out, dist_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit to_s, to_r;
    int off, cnt;
    logic idle5;
    load_test1();
    start_run(2, 3, 1'b0);
    checks++;
    if (bus.sample_in_ready !== 1'b1 || idle !== 1'b0) begin
      errors++; $display("FAIL basic_load_entry: sample_ready=%0b idle=%0b exp 1/0", bus.sample_in_ready, idle);
    end
    feed_samples(2, to_s);
    feed_refs(6, 0, 1'b0, to_r);
    wait_done(off, cnt, idle5);
    checks++;
    if (to_s || to_r || off != 4 || cnt != 1 || idle5 !== 1'b1) begin
      errors++; $display("FAIL basic_timing: to=%0b%0b off=%0d cnt=%0d idle5=%0b exp 00/4/1/1", to_s, to_r, off, cnt, idle5);
    end
    checks++;
    if (ref_id_out !== 8'd1 || dist_out !== '0) begin
      errors++; $display("FAIL basic_result: got id %0d dist %0d exp 1/0", ref_id_out, dist_out);
    end
  endtask

  task automatic test_extremes;
    smp[0]  = 32'h0000_0000; smp[1]  = 32'h0000_0000;
    refw[0] = 32'h0000_FFFF; refw[1] = 32'h0000_0000;
    run_and_check("extreme_sq", 1, 1'b0, 0, 1'b0, 8'd0, 39'h00_FFFE_0001);
    run_and_check("extreme_abs", 1, 1'b1, 0, 1'b0, 8'd0, 39'h00_0000_FFFF);
  endtask

  task automatic test_tie;
    smp[0]  = 32'h0002_0001; smp[1]  = 32'h0004_0003;
    refw[0] = 32'h0001_0003; refw[1] = 32'h0004_0003;
    refw[2] = 32'h0001_0003; refw[3] = 32'h0004_0003;
    run_and_check("tie", 2, 1'b0, 0, 1'b0, 8'd0, 39'd5);
  endtask

  task automatic test_mode_select;
    smp[0]  = 32'h0002_0001; smp[1]  = 32'h0004_0003;
    refw[0] = 32'h0002_0005; refw[1] = 32'h0004_0003;
    refw[2] = 32'h0004_0003; refw[3] = 32'h0004_0005;
    run_and_check("mode_sq", 2, 1'b0, 0, 1'b0, 8'd1, 39'd12);
    run_and_check("mode_abs", 2, 1'b1, 0, 1'b0, 8'd0, 39'd4);
  endtask

  task automatic test_zero_lib;
    bit saw_ready = 1'b0;
    @(negedge clk);
    band_words_in     = 7'd2;
    library_length_in = 9'd0;
    mode_in           = 1'b0;
    start             = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (bus.sample_in_ready === 1'b1) saw_ready = 1'b1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b exp 1", done); end
    checks++;
    if (ref_id_out !== '0 || dist_out !== all_ones) begin
      errors++; $display("FAIL zero_result: got %0d/0x%0h exp 0/0x%0h", ref_id_out, dist_out, all_ones);
    end
    @(negedge clk);
    if (bus.sample_in_ready === 1'b1) saw_ready = 1'b1;
    checks++;
    if (done !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL zero_return: done=%0b idle=%0b exp 0/1", done, idle);
    end
    checks++;
    if (saw_ready) begin errors++; $display("FAIL zero_sample_ready: got 1 exp 0"); end
  endtask

  task automatic test_stall_poke;
    load_test1();
    run_and_check("stall", 3, 1'b0, 50, 1'b1, 8'd1, 39'd0);
  endtask

  task automatic test_reset_midrun;
    bit to_s, to_r;
    load_test1();
    start_run(2, 3, 1'b0);
    feed_samples(2, to_s);
    feed_refs(3, 0, 1'b0, to_r);
    checks++;
    if (to_s || to_r || bus.ref_in_ready !== 1'b1) begin
      errors++; $display("FAIL midrun_setup: to=%0b%0b ref_ready=%0b exp 00/1", to_s, to_r, bus.ref_in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (idle !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || bus.ref_in_ready !== 1'b0
        || bus.sample_in_ready !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_ctrl: idle=%0b ready=%0b done=%0b rr=%0b sr=%0b exp 1/1/0/0/0",
                         idle, ready, done, bus.ref_in_ready, bus.sample_in_ready);
    end
    checks++;
    if (ref_id_out !== '0 || dist_out !== '0) begin
      errors++; $display("FAIL midrun_reset_results: got %0d/0x%0h exp 0/0", ref_id_out, dist_out);
    end
    @(negedge clk);
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL midrun_idle_edge: got %0b exp 1", idle); end
    rst = 1'b0;
    @(negedge clk);
    run_and_check("after_reset", 3, 1'b0, 0, 1'b0, 8'd1, 39'd0);
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    all_ones            = '1;
    rst                 = 1'b1;
    start               = 1'b0;
    band_words_in       = '0;
    library_length_in   = '0;
    mode_in             = 1'b0;
    bus.sample_in_valid = 1'b0;
    bus.sample_in       = '0;
    bus.ref_in_valid    = 1'b0;
    bus.ref_in          = '0;

    test_reset();
    test_basic();
    test_extremes();
    test_tie();
    test_reset_midrun();
    test_mode_select();
    test_zero_lib();
    test_stall_poke();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
